// File: rtl/cpu_core.sv
// Single-cycle 32-bit MIPS-subset core: one instruction retires per rising edge.
// Instruction and data memories are external combinational-read blocks.
module cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] memOut,
    output logic [31:0] PCvalue,
    output logic [31:0] aluRes,
    output logic [31:0] readData1,
    output logic        memRead_en,
    output logic        memWrite_en
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_regs [NREGS];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;
    logic [31:0] w_rsVal;
    logic [31:0] w_rtVal;
    logic [31:0] w_seImm;
    logic [31:0] w_zeImm;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_branchTarget;
    logic        w_unusedShamt;

    logic [31:0] w_aluRes;
    logic [31:0] w_nextPc;
    logic [31:0] w_wrData;
    logic [4:0]  w_wrIdx;
    logic        w_wrEn;
    logic        w_isLoad;
    logic        w_memRead;
    logic        w_memWrite;

    assign w_op          = inst[31:26];
    assign w_rs          = inst[25:21];
    assign w_rt          = inst[20:16];
    assign w_rd          = inst[15:11];
    assign w_funct       = inst[5:0];
    assign w_imm         = inst[15:0];
    assign w_target      = inst[25:0];
    assign w_unusedShamt = ^inst[10:6];

    assign w_rsVal        = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rtVal        = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
    assign w_seImm        = {{16{w_imm[15]}}, w_imm};
    assign w_zeImm        = {16'd0, w_imm};
    assign w_pcPlus4      = r_pc + 32'd4;
    assign w_branchTarget = w_pcPlus4 + {w_seImm[29:0], 2'b00};

    // Decode and execute; a halted core suppresses every side effect and freezes the PC.
    always_comb begin
        w_aluRes   = 32'd0;
        w_nextPc   = w_pcPlus4;
        w_wrEn     = 1'b0;
        w_wrIdx    = 5'd0;
        w_isLoad   = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        if (r_state == ST_HALTED) begin
            w_nextPc = r_pc;
        end else begin
            case (w_op)
                OP_RTYPE: begin
                    w_wrIdx = w_rd;
                    w_wrEn  = 1'b1;
                    case (w_funct)
                        FN_ADD:  w_aluRes = w_rsVal + w_rtVal;
                        FN_SUB:  w_aluRes = w_rsVal - w_rtVal;
                        FN_AND:  w_aluRes = w_rsVal & w_rtVal;
                        FN_OR:   w_aluRes = w_rsVal | w_rtVal;
                        FN_NOR:  w_aluRes = ~(w_rsVal | w_rtVal);
                        FN_SLT:  w_aluRes = ($signed(w_rsVal) < $signed(w_rtVal)) ? 32'd1 : 32'd0;
                        default: w_wrEn   = 1'b0;
                    endcase
                end
                OP_ADDI: begin
                    w_aluRes = w_rsVal + w_seImm;
                    w_wrIdx  = w_rt;
                    w_wrEn   = 1'b1;
                end
                OP_ANDI: begin
                    w_aluRes = w_rsVal & w_zeImm;
                    w_wrIdx  = w_rt;
                    w_wrEn   = 1'b1;
                end
                OP_ORI: begin
                    w_aluRes = w_rsVal | w_zeImm;
                    w_wrIdx  = w_rt;
                    w_wrEn   = 1'b1;
                end
                OP_LW: begin
                    w_aluRes  = w_rsVal + w_seImm;
                    w_wrIdx   = w_rt;
                    w_wrEn    = 1'b1;
                    w_isLoad  = 1'b1;
                    w_memRead = 1'b1;
                end
                OP_SW: begin
                    w_aluRes   = w_rsVal + w_seImm;
                    w_memWrite = 1'b1;
                end
                OP_BEQ: begin
                    w_aluRes = w_rsVal - w_rtVal;
                    if (w_rsVal == w_rtVal) w_nextPc = w_branchTarget;
                end
                OP_BNE: begin
                    w_aluRes = w_rsVal - w_rtVal;
                    if (w_rsVal != w_rtVal) w_nextPc = w_branchTarget;
                end
                OP_J:    w_nextPc = {w_pcPlus4[31:28], w_target, 2'b00};
                OP_HALT: w_nextPc = r_pc;
                default: ;
            endcase
        end
        w_wrData = w_isLoad ? memOut : w_aluRes;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'd0;
        end else begin
            r_pc <= w_nextPc;
            if (r_state == ST_RUN && w_op == OP_HALT) r_state <= ST_HALTED;
            if (w_wrEn && w_wrIdx != 5'd0) r_regs[w_wrIdx] <= w_wrData;
        end
    end

    // Memory enables are gated by reset so nothing is written while it is held.
    assign PCvalue     = r_pc;
    assign aluRes      = w_aluRes;
    assign readData1   = w_rtVal;
    assign memRead_en  = w_memRead & rst;
    assign memWrite_en = w_memWrite & rst;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: an architectural model checked every cycle
// plus directed instruction sequences with hand-computed expectations.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] memOut;
    logic [31:0] PCvalue;
    logic [31:0] aluRes;
    logic [31:0] readData1;
    logic        memRead_en;
    logic        memWrite_en;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    logic [31:0] dmem [256];

    logic [31:0] mPc;
    logic [31:0] mRegs [32];
    logic [31:0] mMem [256];
    bit          mHalt;

    cpu_core #(.RESET_PC(32'h0), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .inst(inst), .memOut(memOut),
        .PCvalue(PCvalue), .aluRes(aluRes), .readData1(readData1),
        .memRead_en(memRead_en), .memWrite_en(memWrite_en)
    );

    always #5 clk = ~clk;

    // External data memory, driven by the DUT's address and store data.
    assign memOut = dmem[aluRes[9:2]];
    always @(posedge clk) if (memWrite_en) dmem[aluRes[9:2]] <= readData1;

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] peek(input logic [4:0] r);
        return rType(5'd0, r, 5'd0, 6'h25);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: one instruction's effect on PC, registers and memory.
    task automatic modelStep();
        logic [31:0] a, b, se, ze, addr, res, nxt;
        logic [5:0]  op, fn;
        bit          wr;
        logic [4:0]  dst;
        op  = inst[31:26];
        fn  = inst[5:0];
        a   = mRegs[inst[25:21]];
        b   = mRegs[inst[20:16]];
        se  = {{16{inst[15]}}, inst[15:0]};
        ze  = {16'd0, inst[15:0]};
        addr = a + se;
        nxt = mPc + 32'd4;
        wr  = 1'b0;
        dst = inst[20:16];
        res = 32'd0;
        case (op)
            6'h00: begin
                dst = inst[15:11];
                wr  = 1'b1;
                case (fn)
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            6'h08: begin res = a + se; wr = 1'b1; end
            6'h0C: begin res = a & ze; wr = 1'b1; end
            6'h0D: begin res = a | ze; wr = 1'b1; end
            6'h23: begin res = mMem[addr[9:2]]; wr = 1'b1; end
            6'h2B: mMem[addr[9:2]] = b;
            6'h04: if (a == b) nxt = mPc + 32'd4 + (se << 2);
            6'h05: if (a != b) nxt = mPc + 32'd4 + (se << 2);
            6'h02: nxt = {nxt[31:28], inst[25:0], 2'b00};
            6'h3F: begin nxt = mPc; mHalt = 1'b1; end
            default: ;
        endcase
        if (wr && dst != 5'd0) mRegs[dst] = res;
        mPc = nxt;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPc   = 32'h0;
            mHalt = 1'b0;
            for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
        end else if (!mHalt) begin
            modelStep();
        end
    end

    // Expected aluRes as {valid, value}; invalid where the result is unconstrained.
    function automatic logic [32:0] expAlu();
        logic [31:0] a, b, se;
        a  = mRegs[inst[25:21]];
        b  = mRegs[inst[20:16]];
        se = {{16{inst[15]}}, inst[15:0]};
        if (mHalt) return {1'b1, 32'd0};
        case (inst[31:26])
            6'h00: case (inst[5:0])
                6'h20: return {1'b1, a + b};
                6'h22: return {1'b1, a - b};
                6'h24: return {1'b1, a & b};
                6'h25: return {1'b1, a | b};
                6'h27: return {1'b1, ~(a | b)};
                6'h2A: return {1'b1, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
                default: return {1'b0, 32'd0};
            endcase
            6'h08, 6'h23, 6'h2B: return {1'b1, a + se};
            6'h0C: return {1'b1, a & {16'd0, inst[15:0]}};
            6'h0D: return {1'b1, a | {16'd0, inst[15:0]}};
            6'h02, 6'h3F: return {1'b1, 32'd0};
            default: return {1'b0, 32'd0};
        endcase
    endfunction

    always @(negedge clk) begin
        if (chkEn) begin
            logic [32:0] ea;
            logic        live;
            ea   = expAlu();
            live = rst && !mHalt;
            checkOutput("model_pc", PCvalue, mPc);
            checkOutput("model_readData1", readData1, mRegs[inst[20:16]]);
            if (ea[32]) checkOutput("model_aluRes", aluRes, ea[31:0]);
            checkOutput("model_memRead_en", {31'd0, memRead_en}, {31'd0, live && inst[31:26] == 6'h23});
            checkOutput("model_memWrite_en", {31'd0, memWrite_en}, {31'd0, live && inst[31:26] == 6'h2B});
        end
    end

    task automatic applyStimulus(input logic [31:0] w);
        inst = w;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runInst(input logic [31:0] w);
        applyStimulus(w);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 32'd0;
            mMem[i] = 32'd0;
        end
        rst  = 1'b0;
        inst = 32'd0;
        #3;
        checkOutput("reset_pc", PCvalue, 32'h0);
        checkOutput("reset_memWrite_en", {31'd0, memWrite_en}, 32'd0);
        #8;
        rst   = 1'b1;
        chkEn = 1'b1;
        #1;
        checkOutput("release_pc0", PCvalue, 32'h0);
        tick();
        checkOutput("release_pc4", PCvalue, 32'h4);
        tick();
        checkOutput("release_pc8", PCvalue, 32'h8);

        runInst(iType(6'h08, 5'd0, 5'd1, 16'd5));
        runInst(iType(6'h08, 5'd0, 5'd2, 16'hFFFD));
        runInst(rType(5'd1, 5'd2, 5'd3, 6'h20));
        runInst(rType(5'd1, 5'd2, 5'd4, 6'h22));
        runInst(rType(5'd2, 5'd1, 5'd5, 6'h2A));
        runInst(rType(5'd1, 5'd1, 5'd0, 6'h20));
        applyStimulus(peek(5'd3)); checkOutput("add_r3", readData1, 32'd2); tick();
        applyStimulus(peek(5'd4)); checkOutput("sub_r4", readData1, 32'd8); tick();
        applyStimulus(peek(5'd5)); checkOutput("slt_r5", readData1, 32'd1); tick();
        applyStimulus(peek(5'd0)); checkOutput("r0_zero", readData1, 32'd0); tick();

        runInst(rType(5'd1, 5'd2, 5'd6, 6'h24));
        runInst(rType(5'd1, 5'd2, 5'd7, 6'h25));
        runInst(rType(5'd1, 5'd2, 5'd8, 6'h27));
        runInst(rType(5'd2, 5'd1, 5'd9, 6'h2A));
        runInst(iType(6'h0C, 5'd2, 5'd10, 16'hF0F0));
        runInst(iType(6'h0D, 5'd1, 5'd11, 16'h8000));
        runInst(rType(5'd1, 5'd2, 5'd12, 6'h18));
        runInst(iType(6'h3E, 5'd1, 5'd13, 16'h1234));
        for (int r = 6; r <= 13; r++) runInst(peek(r[4:0]));
        applyStimulus(peek(5'd10)); checkOutput("andi_zext", readData1, 32'h0000_F0F0); tick();

        runInst(iType(6'h08, 5'd0, 5'd1, 16'h0040));
        runInst(iType(6'h08, 5'd0, 5'd2, 16'h1234));
        applyStimulus(iType(6'h2B, 5'd1, 5'd2, 16'd4));
        checkOutput("sw_aluRes", aluRes, 32'h44);
        checkOutput("sw_readData1", readData1, 32'h1234);
        checkOutput("sw_memWrite_en", {31'd0, memWrite_en}, 32'd1);
        tick();
        applyStimulus(iType(6'h23, 5'd1, 5'd3, 16'd4));
        checkOutput("lw_memRead_en", {31'd0, memRead_en}, 32'd1);
        checkOutput("lw_aluRes", aluRes, 32'h44);
        tick();
        applyStimulus(peek(5'd3)); checkOutput("lw_r3", readData1, 32'h1234); tick();

        applyStimulus(iType(6'h2B, 5'd1, 5'd2, 16'd8));
        rst = 1'b0;
        #1;
        checkOutput("async_pc", PCvalue, 32'h0);
        checkOutput("async_memWrite_en", {31'd0, memWrite_en}, 32'd0);
        checkOutput("async_regs_cleared", readData1, 32'd0);
        tick();
        checkOutput("async_hold_pc", PCvalue, 32'h0);
        rst = 1'b1;
        applyStimulus(iType(6'h23, 5'd0, 5'd4, 16'h0048));
        checkOutput("no_write_in_reset", memOut, 32'd0);
        tick();

        for (int i = 0; i < 3; i++) runInst(32'd0);
        checkOutput("pre_branch_pc", PCvalue, 32'h10);
        runInst(iType(6'h04, 5'd0, 5'd0, 16'd2));
        checkOutput("beq_taken_pc", PCvalue, 32'h1C);
        runInst(iType(6'h05, 5'd0, 5'd0, 16'd5));
        checkOutput("bne_not_taken_pc", PCvalue, 32'h20);
        runInst(iType(6'h08, 5'd0, 5'd1, 16'd1));
        runInst(iType(6'h05, 5'd1, 5'd0, 16'hFFFF));
        runInst(iType(6'h05, 5'd1, 5'd0, 16'hFFFF));
        checkOutput("bne_self_loop_pc", PCvalue, 32'h24);
        runInst(iType(6'h04, 5'd1, 5'd0, 16'd3));
        checkOutput("beq_not_taken_pc", PCvalue, 32'h28);

        runInst({6'h02, 26'h40});
        checkOutput("jump_pc", PCvalue, 32'h100);
        applyStimulus(32'hFC00_0000);
        checkOutput("halt_aluRes", aluRes, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            runInst(32'hFC00_0000);
            checkOutput("halt_pc_frozen", PCvalue, 32'h100);
        end
        runInst(iType(6'h08, 5'd0, 5'd1, 16'd7));
        applyStimulus(iType(6'h2B, 5'd0, 5'd1, 16'd0));
        checkOutput("halted_memWrite_en", {31'd0, memWrite_en}, 32'd0);
        checkOutput("halted_no_reg_write", readData1, 32'd1);
        tick();
        checkOutput("halted_pc", PCvalue, 32'h100);

        chkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Single-cycle 32-bit MIPS-subset processor core: fetch, decode, register file, ALU, branch/jump logic and PC.
- Instruction memory and data memory are external, combinational-read blocks.
- The core presents the PC as the instruction address, and the ALU result plus store data as the data-memory address/write data.
- One instruction retires per rising clock edge; opcode 0x3F (word 0xFC000000) is HALT.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, number of general-purpose registers (5-bit index); register 0 reads zero.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset.
- inst  in  32  instruction word at address PCvalue (combinational from memory).
- memOut  in  32  data-memory read data at address aluRes (combinational).
- PCvalue  out  32  current PC (byte address, word aligned).
- aluRes  out  32  ALU result; serves as the data-memory address for lw/sw.
- readData1  out  32  store data = register[rt] value; valid whenever the instruction is decoded.
- memRead_en  out  1  high only while the current instruction is lw.
- memWrite_en  out  1  high only while the current instruction is sw; memory writes on its clock edge.

Behaviour:
- Reset (rst=0, async):
  - PC <= RESET_PC and all registers <= 0 immediately.
  - memWrite_en and memRead_en are forced 0 while in reset; no register writes occur.
  - Release takes effect from the next rising edge.
- Datapath is single-cycle:
  - Outputs are combinational from PC, inst and the register file.
  - Register write and PC update happen on rising clk.
- Decode fields: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0], target=[25:0].
- R-type (op 0x00), writes rd, by funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 1/0).
  - Any other funct is a NOP.
- I-type:
  - 0x08 addi (sign-extended imm), 0x0C andi (zero-ext), 0x0D ori (zero-ext); all write rt.
  - 0x23 lw: aluRes = rs + sext(imm); rt <= memOut.
  - 0x2B sw: aluRes = rs + sext(imm); readData1 = rt value; memWrite_en=1.
  - 0x04 beq / 0x05 bne: compare rs vs rt; taken target = PC+4 + (sext(imm)<<2).
- J-type 0x02 j: PC <= {PC+4[31:28], target, 2'b00}.
- HALT 0x3F: PC holds its value; no register or memory write; both enables 0. The core stays halted until reset.
- Undefined opcodes execute as NOP with PC+4.
- Arithmetic is 32-bit wrap-around; overflow is ignored with no trap.
- Writes to register 0 are discarded; register 0 always reads 0.
- Register reads are combinational. A write at an edge is visible to the next instruction; there is no same-cycle bypass.
- Default next PC = PC+4, wrapping at 2^32.
- aluRes for non-ALU instructions (j, halt) is 0.

Test Plan:
- Reset: hold rst=0 for 10 ns with inst=0 -> PCvalue=0, memWrite_en=0. After release, PC steps 0,4,8 on successive edges.
- ALU: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1 -> $3=2, $4=8, $5=1. An R-type write to $0 leaves $0=0.
- Memory: $1=0x40, $2=0x1234; sw $2,4($1) -> aluRes=0x44, readData1=0x1234, memWrite_en=1. Then lw $3,4($1) -> memRead_en=1 and $3=0x1234.
- Branches: beq with equal regs at PC=0x10, imm=2 -> next PC=0x1C. bne with equal regs -> PC=0x14. Taken imm=-1 -> PC=0x10 (self-loop).
- Jump/halt: j 0x40 -> PC=0x100. inst=0xFC000000 -> PC frozen for 5 cycles, no writes.
- Async reset mid-run: drop rst between edges -> PC=0 immediately, registers cleared, memWrite_en=0 during reset.
